// File: rtl/sha3_round_feedback_scheduler.sv
// sha3_round_feedback_scheduler
//   Sequences one Keccak job at a time around an external round pipeline.
//   A new 1600-bit state is issued with round 0; each returned state is
//   re-issued with the next round index until the final round comes back,
//   at which point it is presented as the hashed result.
//
//   Each state/result port carries five 64-bit lanes; lane 0 is [63:0].
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   isa..ise, sample     new state to hash, accepted when ready=1
//   ready                scheduler idle and able to take a new state
//   fsa..fse, fgood,     state returned by the round second half and the
//   fround               round index it was processed with (fgood pulses)
//   osa..ose, osample,   state issued to the round first half with its
//   oround               round index (osample pulses)
//   rsa..rse, rgood      final hashed state (rgood pulses)
//   oerr                 sticky protocol-error flag (cleared only by reset)
module sha3_round_feedback_scheduler #(
  parameter int unsigned LAST_ROUND = 23,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [319:0] isa,
  input  logic [319:0] isb,
  input  logic [319:0] isc,
  input  logic [319:0] isd,
  input  logic [319:0] ise,
  input  logic         sample,
  output logic         ready,
  input  logic [319:0] fsa,
  input  logic [319:0] fsb,
  input  logic [319:0] fsc,
  input  logic [319:0] fsd,
  input  logic [319:0] fse,
  input  logic         fgood,
  input  logic [4:0]   fround,
  output logic [319:0] osa,
  output logic [319:0] osb,
  output logic [319:0] osc,
  output logic [319:0] osd,
  output logic [319:0] ose,
  output logic         osample,
  output logic [4:0]   oround,
  output logic [319:0] rsa,
  output logic [319:0] rsb,
  output logic [319:0] rsc,
  output logic [319:0] rsd,
  output logic [319:0] rse,
  output logic         rgood,
  output logic         oerr
);

  // Watchdog counts 0..TIMEOUT-1 cycles since the last issue; expiry is the
  // edge taken while the count sits at TIMEOUT-1.
  localparam int unsigned   WDW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam logic [4:0]    LAST_R  = 5'(LAST_ROUND);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state, state_n;
  logic [4:0]     exp_round;
  logic [WDW-1:0] wd;

  logic issue_new;
  logic issue_fb;
  logic finish;
  logic err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // Feedback is evaluated before the watchdog so a return on the expiry
  // edge wins and does not raise oerr.
  always_comb begin
    state_n   = state;
    issue_new = 1'b0;
    issue_fb  = 1'b0;
    finish    = 1'b0;
    err       = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (sample) begin
          issue_new = 1'b1;
          state_n   = RUN;
        end
        if (fgood) err = 1'b1;
      end
      RUN: begin
        if (fgood) begin
          if (fround != exp_round) begin
            err     = 1'b1;
            state_n = IDLE;
          end else if (exp_round == LAST_R) begin
            finish  = 1'b1;
            state_n = IDLE;
          end else begin
            issue_fb = 1'b1;
          end
        end else if (WD_EN && wd == WD_LAST) begin
          err     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      osa       <= '0;
      osb       <= '0;
      osc       <= '0;
      osd       <= '0;
      ose       <= '0;
      oround    <= '0;
      osample   <= 1'b0;
      rsa       <= '0;
      rsb       <= '0;
      rsc       <= '0;
      rsd       <= '0;
      rse       <= '0;
      rgood     <= 1'b0;
      oerr      <= 1'b0;
      exp_round <= '0;
      wd        <= '0;
    end else begin
      osample <= issue_new | issue_fb;
      rgood   <= finish;
      if (err) oerr <= 1'b1;

      if (issue_new) begin
        osa       <= isa;
        osb       <= isb;
        osc       <= isc;
        osd       <= isd;
        ose       <= ise;
        oround    <= '0;
        exp_round <= '0;
      end else if (issue_fb) begin
        // issue_fb implies fround < LAST_ROUND, so +1 cannot pass it.
        osa       <= fsa;
        osb       <= fsb;
        osc       <= fsc;
        osd       <= fsd;
        ose       <= fse;
        oround    <= fround + 5'd1;
        exp_round <= fround + 5'd1;
      end

      if (finish) begin
        rsa <= fsa;
        rsb <= fsb;
        rsc <= fsc;
        rsd <= fsd;
        rse <= fse;
      end

      if (WD_EN && state == RUN && state_n == RUN && !issue_fb)
        wd <= wd + WDW'(1);
      else
        wd <= '0;
    end
  end

endmodule

// File: tb/tb_sha3_round_feedback_scheduler.sv
// Testbench for sha3_round_feedback_scheduler (TIMEOUT overridden to 8).
// An echo process plays the external round loop: it returns each issued
// state after a programmable latency with lane 0 incremented by one.
// Stimulus pushes the expected issue/result sequence into a scoreboard
// queue; a monitor pops and compares on every osample/rgood pulse.
module tb_sha3_round_feedback_scheduler;
  localparam int unsigned W = 320;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] isa, isb, isc, isd, ise;
  logic         sample;
  logic         ready;
  logic [W-1:0] fsa, fsb, fsc, fsd, fse;
  logic         fgood;
  logic [4:0]   fround;
  logic [W-1:0] osa, osb, osc, osd, ose;
  logic         osample;
  logic [4:0]   oround;
  logic [W-1:0] rsa, rsb, rsc, rsd, rse;
  logic         rgood;
  logic         oerr;

  sha3_round_feedback_scheduler #(.LAST_ROUND(23), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(sample), .ready(ready),
    .fsa(fsa), .fsb(fsb), .fsc(fsc), .fsd(fsd), .fse(fse),
    .fgood(fgood), .fround(fround),
    .osa(osa), .osb(osb), .osc(osc), .osd(osd), .ose(ose),
    .osample(osample), .oround(oround),
    .rsa(rsa), .rsb(rsb), .rsc(rsc), .rsd(rsd), .rse(rse),
    .rgood(rgood), .oerr(oerr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           kind;   // 0: osample, 1: rgood
    logic [4:0]   rnd;
    logic [W-1:0] a, b, c, d, e;
    int unsigned  at;
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    ntot++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t x;
    bit   ok;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (osample && rgood) begin
          ntot++;
          $display("FAIL pulse_overlap: osample=1 rgood=1 at cycle %0d, required never both", cyc);
        end
        if (osample || rgood) begin
          if (sbq.size() == 0) begin
            ntot++;
            $display("FAIL unexpected_output: osample=%0b rgood=%0b oround=%0d at cycle %0d, required none",
                     osample, rgood, oround, cyc);
          end else begin
            x = sbq.pop_front();
            if (x.kind == 1'b0)
              ok = osample && !rgood && oround === x.rnd && osa === x.a && osb === x.b &&
                   osc === x.c && osd === x.d && ose === x.e && cyc == x.at;
            else
              ok = rgood && !osample && rsa === x.a && rsb === x.b &&
                   rsc === x.c && rsd === x.d && rse === x.e && cyc == x.at;
            ntot++;
            if (ok) npass++;
            else if (x.kind == 1'b0)
              $display("FAIL sb_osample r%0d: got osample=%0b round=%0d osa0=%0h ose0=%0h cycle=%0d, expected round=%0d osa0=%0h ose0=%0h cycle=%0d",
                       x.rnd, osample, oround, osa[63:0], ose[63:0], cyc, x.rnd, x.a[63:0], x.e[63:0], x.at);
            else
              $display("FAIL sb_rgood: got rgood=%0b rsa0=%0h rse0=%0h cycle=%0d, expected rsa0=%0h rse0=%0h cycle=%0d",
                       rgood, rsa[63:0], rse[63:0], cyc, x.a[63:0], x.e[63:0], x.at);
          end
        end
      end
    end
  end

  // Echo model of the external round loop
  int unsigned  lat     = 2;
  bit           echo_on = 1'b1;
  int           bad_at  = -1;
  bit           kill    = 1'b0;
  bit           pend    = 1'b0;
  bit           drove   = 1'b0;
  int unsigned  cnt;
  logic [4:0]   er;
  logic [W-1:0] ea, eb, ec, ed, ee;

  initial begin
    forever begin
      @(negedge clk);
      if (drove) begin
        fgood = 1'b0;
        drove = 1'b0;
      end
      if (!rstn || kill) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend   = 1'b0;
          drove  = 1'b1;
          fgood  = 1'b1;
          fround = (int'(er) == bad_at) ? er + 5'd1 : er;
          fsa    = ea + W'(1);
          fsb    = eb;
          fsc    = ec;
          fsd    = ed;
          fse    = ee;
        end
      end
      if (rstn && !kill && osample && echo_on) begin
        pend = 1'b1;
        cnt  = lat;
        er   = oround;
        ea   = osa;
        eb   = osb;
        ec   = osc;
        ed   = osd;
        ee   = ose;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later.
  task automatic start_job(input logic [W-1:0] a, b, c, d, e,
                           input int unsigned nexp, input bit done,
                           output int unsigned n);
    exp_t x;
    n = cyc;
    isa = a; isb = b; isc = c; isd = d; ise = e;
    sample = 1'b1;
    for (int unsigned r = 0; r < nexp; r++) begin
      x.kind = 1'b0; x.rnd = 5'(r);
      x.a = a + W'(r); x.b = b; x.c = c; x.d = d; x.e = e;
      x.at = n + 1 + r * (lat + 1);
      sbq.push_back(x);
    end
    if (done) begin
      x.kind = 1'b1; x.rnd = '0;
      x.a = a + W'(24); x.b = b; x.c = c; x.d = d; x.e = e;
      x.at = n + 24 * (lat + 1) + 1;
      sbq.push_back(x);
    end
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic drain(input string nm, input int unsigned budget);
    int unsigned k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    ntot++;
    if (sbq.size() == 0) npass++;
    else $display("FAIL %s: %0d expected outputs still pending after %0d cycles", nm, sbq.size(), budget);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [W-1:0] pa = {64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  logic [W-1:0] pb = {64'h1111_2222_3333_4444, 64'h5, 64'h6, 64'h7, 64'h8};
  logic [W-1:0] pe = {64'hDEAD_BEEF_0000_0001, 64'h0, 64'h0, 64'h0, 64'hCAFE};

  initial begin
    int unsigned n;
    bit          busy_seen_high;
    rstn = 1'b0; sample = 1'b0; fgood = 1'b0; fround = '0;
    isa = '0; isb = '0; isc = '0; isd = '0; ise = '0;
    fsa = '0; fsb = '0; fsc = '0; fsd = '0; fse = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_pulses", W'({osample, rgood, oerr}), '0);
    chk("rst_oround", W'(oround), '0);
    chk("rst_state_words", osa | osb | osc | osd | ose, '0);
    chk("rst_result_words", rsa | rsb | rsc | rsd | rse, '0);

    // Nominal: sample on the first edge after release, loop latency 2
    rstn = 1'b1;
    start_job(W'(64'h6), '0, '0, '0, '0, 24, 1'b1, n);
    drain("nominal_drain", 200);
    chk("nominal_oerr", W'(oerr), '0);
    chk("nominal_ready_after", W'(ready), W'(1));

    // Busy rejection: stray samples during RUN must not disturb the job
    start_job(W'(64'h100), pb, pa, pb, pe, 24, 1'b1, n);
    busy_seen_high = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (ready) busy_seen_high = 1'b1;
      isa = W'(64'hFF);
      sample = (k % 3 == 0);
      @(negedge clk);
    end
    sample = 1'b0;
    chk("busy_ready_low", W'(busy_seen_high), '0);
    drain("busy_drain", 200);

    // Feedback on the watchdog expiry edge wins
    lat = 7;
    start_job(W'(64'h2000), pe, pb, pa, pb, 24, 1'b1, n);
    drain("wd_edge_drain", 400);
    chk("wd_edge_oerr", W'(oerr), '0);
    lat = 2;

    // Round mismatch: round 4 returned as 5
    bad_at = 4;
    start_job(W'(64'h300), pb, pb, pb, pb, 5, 1'b0, n);
    wait_cyc(n + 15);
    chk("mismatch_oerr_before", W'(oerr), '0);
    @(negedge clk);
    chk("mismatch_oerr", W'(oerr), W'(1));
    chk("mismatch_ready", W'(ready), W'(1));
    bad_at = -1;
    repeat (20) @(negedge clk);
    drain("mismatch_drain", 5);

    // Watchdog expiry with no feedback at all
    reset_pulse();
    chk("rst_clears_oerr", W'(oerr), '0);
    echo_on = 1'b0;
    start_job(W'(64'h400), pa, pb, pa, pe, 1, 1'b0, n);
    wait_cyc(n + 8);
    chk("wd_oerr_cycle7", W'(oerr), '0);
    chk("wd_ready_cycle7", W'(ready), '0);
    @(negedge clk);
    chk("wd_oerr_cycle8", W'(oerr), W'(1));
    chk("wd_ready_cycle8", W'(ready), W'(1));
    echo_on = 1'b1;
    drain("wd_drain", 5);

    // Spurious feedback in IDLE, then a normal job
    reset_pulse();
    fgood = 1'b1; fround = 5'd0;
    @(negedge clk);
    fgood = 1'b0;
    chk("spurious_oerr", W'(oerr), W'(1));
    chk("spurious_ready", W'(ready), W'(1));
    repeat (3) @(negedge clk);
    start_job(W'(64'h500), pe, pe, pe, pe, 24, 1'b1, n);
    drain("spurious_job_drain", 200);
    chk("oerr_sticky", W'(oerr), W'(1));

    // Reset in the middle of round 10
    start_job(W'(64'h600), pb, pe, pb, pe, 11, 1'b0, n);
    wait_cyc(n + 32);
    chk("midrst_sb_empty", W'(sbq.size()), '0);
    rstn = 1'b0;
    kill = 1'b1;
    @(negedge clk);
    chk("midrst_pulses", W'({osample, rgood, oerr}), '0);
    chk("midrst_ready", W'(ready), W'(1));
    chk("midrst_oround", W'(oround), '0);
    chk("midrst_words", osa | osb | osc | osd | ose | rsa | rsb | rsc | rsd | rse, '0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    kill = 1'b0;
    repeat (80) @(negedge clk);
    start_job(W'(64'h700), pa, pa, pb, pb, 24, 1'b1, n);
    drain("post_reset_job_drain", 200);
    chk("post_reset_oerr", W'(oerr), '0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, %0d/%0d so far", npass, ntot);
    $fatal(1);
  end

endmodule
